vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen_if.sv | 27 ++
 rtl/vga_timing_gen.sv | 169 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
//==============================================================================
// Module  : vga_timing_if
// Brief   : Raster timing bundle from the VGA timing generator to the pixel
//           stage and sync connector.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

interface vga_timing_if;
  logic       pix_tick;
  logic [9:0] x;
  logic [8:0] y;
  logic       active;
  logic       hsync;
  logic       vsync;
  logic       frame_start;

  modport master (
    output pix_tick, x, y, active, hsync, vsync, frame_start
  );

  modport slave (
    input pix_tick, x, y, active, hsync, vsync, frame_start
  );
endinterface

`default_nettype wire

// File: rtl/vga_timing_gen.sv
//==============================================================================
// Module  : vga_timing_gen
// Brief   : 640x480@60 VGA raster timing generator. Divides the system clock
//           down to a pixel strobe, runs horizontal/vertical counters and
//           produces registered sync, active-video, coordinate and
//           frame-start outputs.
// Options : VGA_SYNC_DELAY_EN - delays hsync/vsync/active by one pixel period
//           to line up with a registered colour stage.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  vga_timing_if.master  vga
);

  localparam int unsigned C_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned C_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned C_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(CLK_DIV - 1);
  localparam logic [C_DIV_W-1:0] C_DIV_ONE  = C_DIV_W'(1);
  localparam logic [9:0] C_H_LAST   = 10'(C_H_TOTAL - 1);
  localparam logic [9:0] C_V_LAST   = 10'(C_V_TOTAL - 1);
  localparam logic [9:0] C_H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] C_V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] C_HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] C_HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] C_VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] C_VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [C_DIV_W-1:0] r_div_cnt;
  logic [9:0]         r_h_cnt;
  logic [9:0]         r_v_cnt;

  logic               w_en;
  logic               w_h_wrap;
  logic [9:0]         w_h_next;
  logic [9:0]         w_v_next;
  logic               w_active_next;
  logic               w_hsync_next;
  logic               w_vsync_next;
  logic               w_frame_next;

  logic               r_pix_tick;
  logic               r_frame_start;
  logic               r_active;
  logic [9:0]         r_x;
  logic [8:0]         r_y;
  logic               r_hsync;
  logic               r_vsync;

  // Pixel enable: last count of the divider. With CLK_DIV=1 the divider
  // sits at zero, which equals its last value, so the enable is constant.
  assign w_en = (r_div_cnt == C_DIV_LAST);

  // Clock divider counting 0..CLK_DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
    end else if (w_en) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + C_DIV_ONE;
    end
  end

  // Next raster position and the output values decoded from it.
  always_comb begin
    w_h_wrap = (r_h_cnt == C_H_LAST);
    w_h_next = w_h_wrap ? 10'd0 : r_h_cnt + 10'd1;
    w_v_next = r_v_cnt;
    if (w_h_wrap) begin
      w_v_next = (r_v_cnt == C_V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
    end
    w_active_next = (w_h_next < C_H_ACT) && (w_v_next < C_V_ACT);
    w_hsync_next  = ((w_h_next >= C_HS_FIRST) && (w_h_next <= C_HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    w_vsync_next  = ((w_v_next >= C_VS_FIRST) && (w_v_next <= C_VS_LAST)) ? SYNC_POL : ~SYNC_POL;
    w_frame_next  = (w_h_next == 10'd0) && (w_v_next == 10'd0);
  end

  // Raster counters advance once per pixel. They reset to the last position
  // so the first enable lands on (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= C_H_LAST;
      r_v_cnt <= C_V_LAST;
    end else if (w_en) begin
      r_h_cnt <= w_h_next;
      r_v_cnt <= w_v_next;
    end
  end

  // Single-cycle strobes that follow each pixel enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_tick    <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_pix_tick    <= w_en;
      r_frame_start <= w_en && w_frame_next;
    end
  end

  // Position, blanking and sync outputs, held for the whole pixel period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_hsync  <= ~SYNC_POL;
      r_vsync  <= ~SYNC_POL;
    end else if (w_en) begin
      r_active <= w_active_next;
      r_x      <= w_active_next ? w_h_next : 10'd0;
      r_y      <= w_active_next ? w_v_next[8:0] : 9'd0;
      r_hsync  <= w_hsync_next;
      r_vsync  <= w_vsync_next;
    end
  end

  assign vga.pix_tick    = r_pix_tick;
  assign vga.frame_start = r_frame_start;
  assign vga.x           = r_x;
  assign vga.y           = r_y;

`ifdef VGA_SYNC_DELAY_EN
  logic r_active_d;
  logic r_hsync_d;
  logic r_vsync_d;

  // Extra pixel of delay on sync/blanking so they line up with registered RGB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active_d <= 1'b0;
      r_hsync_d  <= ~SYNC_POL;
      r_vsync_d  <= ~SYNC_POL;
    end else if (w_en) begin
      r_active_d <= r_active;
      r_hsync_d  <= r_hsync;
      r_vsync_d  <= r_vsync;
    end
  end

  assign vga.active = r_active_d;
  assign vga.hsync  = r_hsync_d;
  assign vga.vsync  = r_vsync_d;
`else
  assign vga.active = r_active;
  assign vga.hsync  = r_hsync;
  assign vga.vsync  = r_vsync;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
//==============================================================================
// Module  : tb_vga_timing_gen
// Brief   : Self-checking bench for vga_timing_gen. Instance A uses the full
//           640x480 geometry at CLK_DIV=4; instance B uses a reduced raster
//           at CLK_DIV=1 with active-high sync so whole frames fit in a
//           short run. Expected per-tick outputs come from a raster model
//           queued at reset release and popped on each observed pix_tick.
// Options : VGA_SYNC_DELAY_EN - bench expects the delayed sync/active stage.
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vga_timing_gen;

  localparam int A_DIV = 4;
  localparam int A_HA = 640, A_HF = 16, A_HS = 96, A_HB = 48;
  localparam int A_VA = 480, A_VF = 10, A_VS = 2,  A_VB = 33;

  localparam int B_DIV = 1;
  localparam int B_HA = 16, B_HF = 4, B_HS = 6, B_HB = 4;
  localparam int B_VA = 8,  B_VF = 2, B_VS = 2, B_VB = 3;
  localparam int B_FRAME = (B_HA + B_HF + B_HS + B_HB) * (B_VA + B_VF + B_VS + B_VB);

`ifdef VGA_SYNC_DELAY_EN
  localparam bit DLY = 1'b1;
`else
  localparam bit DLY = 1'b0;
`endif

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic       act;
    logic       hs;
    logic       vs;
    logic       fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a_n;
  logic rst_b_n;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vga_timing_if ifa ();
  vga_timing_if ifb ();

  vga_timing_gen #(
    .CLK_DIV (A_DIV)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_a_n),
    .vga   (ifa)
  );

  vga_timing_gen #(
    .CLK_DIV  (B_DIV),
    .H_ACTIVE (B_HA), .H_FP (B_HF), .H_SYNC (B_HS), .H_BP (B_HB),
    .V_ACTIVE (B_VA), .V_FP (B_VF), .V_SYNC (B_VS), .V_BP (B_VB),
    .SYNC_POL (1'b1)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_b_n),
    .vga   (ifb)
  );

  // Reference raster: outputs presented at pixel index p after reset release.
  function automatic exp_t model(input int p, input int ha, input int hf, input int hs, input int hb,
                                 input int va, input int vf, input int vs, input int vb, input bit pol);
    int   ht = ha + hf + hs + hb;
    int   vt = va + vf + vs + vb;
    int   h  = p % ht;
    int   v  = (p / ht) % vt;
    exp_t e;
    e.act = (h < ha) && (v < va);
    e.x   = e.act ? 10'(h) : 10'd0;
    e.y   = e.act ? 9'(v) : 9'd0;
    e.hs  = (h >= ha + hf && h < ha + hf + hs) ? pol : ~pol;
    e.vs  = (v >= va + vf && v < va + vf + vs) ? pol : ~pol;
    e.fs  = (h == 0) && (v == 0);
    return e;
  endfunction

  function automatic exp_t sample_a();
    exp_t g;
    g.x = ifa.x; g.y = ifa.y; g.act = ifa.active;
    g.hs = ifa.hsync; g.vs = ifa.vsync; g.fs = ifa.frame_start;
    return g;
  endfunction

  function automatic exp_t sample_b();
    exp_t g;
    g.x = ifb.x; g.y = ifb.y; g.act = ifb.active;
    g.hs = ifb.hsync; g.vs = ifb.vsync; g.fs = ifb.frame_start;
    return g;
  endfunction

  task automatic test_reset();
    logic [23:0] got_a, got_b;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (3) @(negedge clk);
    got_a = {ifa.pix_tick, ifa.frame_start, ifa.active, ifa.x, ifa.y, ifa.hsync, ifa.vsync};
    got_b = {ifb.pix_tick, ifb.frame_start, ifb.active, ifb.x, ifb.y, ifb.hsync, ifb.vsync};
    n_cmp++;
    if (got_a !== {3'b000, 10'd0, 9'd0, 2'b11}) begin
      n_bad++;
      $display("FAIL reset_a: got %h want %h", got_a, {3'b000, 10'd0, 9'd0, 2'b11});
    end
    n_cmp++;
    if (got_b !== {3'b000, 10'd0, 9'd0, 2'b00}) begin
      n_bad++;
      $display("FAIL reset_b: got %h want %h", got_b, {3'b000, 10'd0, 9'd0, 2'b00});
    end
  endtask

  // Two-plus lines on the full-size raster, tick-by-tick against the model.
  task automatic test_lines_a();
    int         nt = 1700;
    int         clks = 0;
    int         last_tick = 0;
    int         ticks = 0;
    int         hs_cnt = 0;
    int         hs_first = -1;
    int         act_cnt = 0;
    logic [9:0] held_x = 10'd0;
    exp_t       e, t, prev, got;
    prev = '0; prev.hs = 1'b1; prev.vs = 1'b1;
    for (int p = 0; p < nt; p++) begin
      e = model(p, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, 1'b0);
      if (DLY) begin
        t = e;
        e.act = prev.act; e.hs = prev.hs; e.vs = prev.vs;
        prev = t;
      end
      q_a.push_back(e);
    end
    @(negedge clk);
    rst_a_n = 1'b1;
    while (q_a.size() > 0 && clks < nt * A_DIV + 40) begin
      @(negedge clk);
      clks++;
      if (ifa.pix_tick) begin
        e   = q_a.pop_front();
        got = sample_a();
        n_cmp++;
        if (got !== e) begin
          n_bad++;
          $display("FAIL lines_a tick %0d: got %h want %h", ticks, got, e);
        end
        n_cmp++;
        if (clks - last_tick != A_DIV) begin
          n_bad++;
          $display("FAIL lines_a spacing tick %0d: got %0d clks want %0d", ticks, clks - last_tick, A_DIV);
        end
        last_tick = clks;
        if (ticks < 800) begin
          if (ifa.hsync == 1'b0) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = ticks;
          end
          if (ifa.active) act_cnt++;
        end
        held_x = ifa.x;
        ticks++;
      end else begin
        n_cmp++;
        if (ifa.frame_start !== 1'b0 || ifa.x !== held_x) begin
          n_bad++;
          $display("FAIL lines_a hold clk %0d: fs %b x %0d want fs 0 x %0d", clks, ifa.frame_start, ifa.x, held_x);
        end
      end
    end
    n_cmp++;
    if (q_a.size() != 0) begin
      n_bad++;
      $display("FAIL lines_a timeout: %0d ticks left want 0", q_a.size());
      q_a.delete();
    end
    n_cmp++;
    if (hs_cnt != A_HS) begin
      n_bad++;
      $display("FAIL lines_a hsync_width: got %0d want %0d", hs_cnt, A_HS);
    end
    n_cmp++;
    if (hs_first != A_HA + A_HF + int'(DLY)) begin
      n_bad++;
      $display("FAIL lines_a hsync_start: got %0d want %0d", hs_first, A_HA + A_HF + int'(DLY));
    end
    n_cmp++;
    if (act_cnt != A_HA) begin
      n_bad++;
      $display("FAIL lines_a active_count: got %0d want %0d", act_cnt, A_HA);
    end
  endtask

  // Three full frames on the reduced raster with CLK_DIV=1 and active-high sync.
  task automatic test_frame_b();
    int   nt = 3 * B_FRAME + 1;
    int   clks = 0;
    int   last_tick = 0;
    int   last_fs = -1;
    int   n_fs = 0;
    int   ticks = 0;
    exp_t e, t, prev, got;
    prev = '0; prev.hs = 1'b0; prev.vs = 1'b0;
    for (int p = 0; p < nt; p++) begin
      e = model(p, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, 1'b1);
      if (DLY) begin
        t = e;
        e.act = prev.act; e.hs = prev.hs; e.vs = prev.vs;
        prev = t;
      end
      q_b.push_back(e);
    end
    @(negedge clk);
    rst_b_n = 1'b1;
    while (q_b.size() > 0 && clks < nt * B_DIV + 40) begin
      @(negedge clk);
      clks++;
      if (ifb.pix_tick) begin
        e   = q_b.pop_front();
        got = sample_b();
        n_cmp++;
        if (got !== e) begin
          n_bad++;
          $display("FAIL frame_b tick %0d: got %h want %h", ticks, got, e);
        end
        n_cmp++;
        if (clks - last_tick != B_DIV) begin
          n_bad++;
          $display("FAIL frame_b spacing tick %0d: got %0d clks want %0d", ticks, clks - last_tick, B_DIV);
        end
        last_tick = clks;
        if (ifb.frame_start) begin
          if (last_fs >= 0) begin
            n_cmp++;
            if (clks - last_fs != B_FRAME * B_DIV) begin
              n_bad++;
              $display("FAIL frame_b period: got %0d clks want %0d", clks - last_fs, B_FRAME * B_DIV);
            end
          end
          last_fs = clks;
          n_fs++;
        end
        ticks++;
      end else begin
        n_cmp++;
        if (ifb.frame_start !== 1'b0) begin
          n_bad++;
          $display("FAIL frame_b fs_without_tick clk %0d: got %b want 0", clks, ifb.frame_start);
        end
      end
    end
    n_cmp++;
    if (q_b.size() != 0) begin
      n_bad++;
      $display("FAIL frame_b timeout: %0d ticks left want 0", q_b.size());
      q_b.delete();
    end
    n_cmp++;
    if (n_fs != 4) begin
      n_bad++;
      $display("FAIL frame_b frame_count: got %0d want 4", n_fs);
    end
  endtask

  // Reset asserted between clock edges mid-line; outputs must clear at once
  // and the raster must restart with the same latency as after power-up.
  task automatic test_midframe_reset_a();
    int          budget = 0;
    int          clks = 0;
    logic [23:0] got;
    logic [23:0] want;
    while (!(ifa.active === 1'b1 && ifa.x === 10'd300) && budget < 4000) begin
      @(negedge clk);
      budget++;
    end
    n_cmp++;
    if (budget >= 4000) begin
      n_bad++;
      $display("FAIL midreset_a wait_x300: got timeout want x=300");
    end
    #2;
    rst_a_n = 1'b0;
    #1;
    got = {ifa.pix_tick, ifa.frame_start, ifa.active, ifa.x, ifa.y, ifa.hsync, ifa.vsync};
    n_cmp++;
    if (got !== {3'b000, 10'd0, 9'd0, 2'b11}) begin
      n_bad++;
      $display("FAIL midreset_a async_clear: got %h want %h", got, {3'b000, 10'd0, 9'd0, 2'b11});
    end
    @(negedge clk);
    rst_a_n = 1'b1;
    while (ifa.pix_tick !== 1'b1 && clks < 20) begin
      @(negedge clk);
      clks++;
    end
    n_cmp++;
    if (clks != A_DIV) begin
      n_bad++;
      $display("FAIL midreset_a latency: got %0d clks want %0d", clks, A_DIV);
    end
    got  = {ifa.pix_tick, ifa.frame_start, ifa.active, ifa.x, ifa.y, ifa.hsync, ifa.vsync};
    want = {2'b11, ~DLY, 10'd0, 9'd0, 2'b11};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL midreset_a first_tick: got %h want %h", got, want);
    end
  endtask

  initial begin
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    test_reset();
    test_lines_a();
    test_frame_b();
    test_midframe_reset_a();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
